// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic bit width_ok(input int w);
    return (w >= NIB_W) && ((w % NIB_W) == 0);
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// Four-bit carry-lookahead slice: sum, carry-out and group propagate.
module cla_seq_adder_ctrl_cla4
  import cla_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout,
  output logic             pg
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;
  logic             gg;

  assign p = a ^ b;
  assign g = a & b;

  // Carries computed in parallel from generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
  assign c[4] = gg | (pg & cin);

  assign sum  = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Wide adder built by running one 4-bit CLA slice over the operands, LSB nibble first.
// Define CLA_SEQ_SUB_EN to add the in_sub port (A-B via inverted B and forced carry-in).
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_prop
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cla_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             prop_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [NIB_W-1:0] slice_a;
  logic [NIB_W-1:0] slice_b;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_pg;
  logic             accept;
  logic             last;
  logic             b_inv;
  logic             cin_eff;

`ifdef CLA_SEQ_SUB_EN
  assign b_inv   = in_sub;
  assign cin_eff = in_sub | in_carry;
`else
  assign b_inv   = 1'b0;
  assign cin_eff = in_carry;
`endif

  assign slice_a = a_q[idx_q*NIB_W +: NIB_W];
  assign slice_b = b_q[idx_q*NIB_W +: NIB_W];
  assign last    = (state_q == BUSY) && (idx_q == LAST_IDX);

  cla_seq_adder_ctrl_cla4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .pg   (slice_pg)
  );

  // Working sum with the current nibble merged in; becomes out_sum on the last pass.
  always_comb begin
    sum_d = sum_q;
    sum_d[idx_q*NIB_W +: NIB_W] = slice_sum;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      prop_q    <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_prop  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= '0;
        carry_q <= cin_eff;
        prop_q  <= 1'b1;
      end else if (state_q == BUSY) begin
        idx_q   <= idx_q + 1'b1;
        carry_q <= slice_cout;
        prop_q  <= prop_q & slice_pg;
        if (last) begin
          out_sum   <= sum_d;
          out_carry <= slice_cout;
          out_ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          out_prop  <= prop_q & slice_pg;
        end
      end
    end
  end

  // Operand and partial-sum storage carries no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b ^ {WIDTH{b_inv}};
    end
    if (state_q == BUSY) sum_q <= sum_d;
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomised and directed checks of cla_seq_adder_ctrl against an arithmetic model.
module tb_cla_seq_adder_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_carry = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             out_prop;
`ifdef CLA_SEQ_SUB_EN
  logic             in_sub = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_c;
  logic             exp_ov;
  logic             exp_pr;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CLA_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_prop  (out_prop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word arithmetic: A + B_eff + cin as an unsigned (WIDTH+1)-bit sum.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   t;
    be      = sub ? ~b : b;
    t       = {1'b0, a} + {1'b0, be} + (WIDTH+1)'(sub ? 1'b1 : cin);
    exp_sum = t[WIDTH-1:0];
    exp_c   = t[WIDTH];
    exp_ov  = (a[WIDTH-1] == be[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);
    exp_pr  = &(a ^ be);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) seen = 1;
    end
    if (!seen) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_carry = cin;
`ifdef CLA_SEQ_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model(a, b, cin, sub);
  endtask

  task automatic await_result(input bit junk);
    int cyc = 0;
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (junk) begin
        in_valid = 1'($urandom % 2);
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_carry = 1'($urandom % 2);
      end
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
      else chk("busy_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(NIBBLES));
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_sum"},   32'(out_sum),   32'(exp_sum));
    chk({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(exp_ov));
    chk({tag, "_prop"},  32'(out_prop),  32'(exp_pr));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready",  32'(in_ready),  32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ever_valid;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;

    // Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_out_prop",  32'(out_prop),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    await_result(0);
    check_result("add_5555");
    chk("add_5555_lit", 32'(out_sum), 32'h5555);

    // Backpressure with a competing request
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        in_a = 16'h1111; in_b = 16'h1111; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_sum",       32'(out_sum),   32'h5555);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    repeat (2) @(negedge clk);
    chk("bp_not_taken", 32'(in_ready),  32'd1);
    chk("idle_hold_sum", 32'(out_sum),  32'h5555);

    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    await_result(0);
    check_result("wrap");
    chk("wrap_prop_lit", 32'(out_prop), 32'd1);
    release_out();

    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    await_result(0);
    check_result("ovf");
    chk("ovf_lit", 32'(out_ovf), 32'd1);
    release_out();

    // Abort during the second BUSY cycle
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_sum",   32'(out_sum),   32'd0);
    chk("abort_out_carry", 32'(out_carry), 32'd0);
    chk("abort_out_ovf",   32'(out_ovf),   32'd0);
    chk("abort_out_prop",  32'(out_prop),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ever_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ever_valid = 1;
    end
    chk("abort_no_valid", 32'(ever_valid), 32'd0);

    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    await_result(0);
    check_result("post_abort");
    chk("post_abort_lit", 32'(out_sum), 32'h0002);
    release_out();

`ifdef CLA_SEQ_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    await_result(0);
    check_result("sub_neg");
    chk("sub_neg_lit", 32'(out_sum), 32'hFFFE);
    release_out();

    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    await_result(0);
    check_result("sub_ovf");
    chk("sub_ovf_lit", 32'({out_sum, out_carry, out_ovf}), 32'({16'h7FFF, 1'b1, 1'b1}));
    release_out();
`endif

    for (int n = 0; n < 25; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom % 2);
`ifdef CLA_SEQ_SUB_EN
      rs = 1'($urandom % 2);
`else
      rs = 1'b0;
`endif
      issue(ra, rb, rc, rs);
      await_result(1);
      repeat ($urandom % 3) @(negedge clk);
      check_result("rand");
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
